spi_nav_responder: RTL and testbench

SPI_NAV_RESPONDER -- requirements
Module: spi_nav_responder

---
 rtl/spi_nav_pkg.sv | 25 ++
 rtl/spi_sync_edge.sv | 48 ++++
 rtl/spi_nav_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_nav_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_nav_pkg.sv
// spi_nav_pkg
//   Shared types and register map constants for the pmod_nav SPI responder.
//   - state_e    : transfer FSM states
//   - WHO_AM_I   : read-only identity register address
//   - STATUS     : status register address (bit0 = data ready)
//   - OUT_FIRST/OUT_LAST : sensor output window whose update sets data ready
package spi_nav_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_e;

    localparam logic [5:0] WHO_AM_I  = 6'h0F;
    localparam logic [5:0] STATUS    = 6'h27;
    localparam logic [5:0] OUT_FIRST = 6'h28;
    localparam logic [5:0] OUT_LAST  = 6'h2D;

    function automatic logic in_out_range(input logic [5:0] addr);
        return (addr >= OUT_FIRST) && (addr <= OUT_LAST);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Multi-flop synchronizer for one asynchronous input plus rise/fall pulse
//   detection on the synchronized value.
//   Ports:
//     clk  : system clock
//     rst  : asynchronous active-low reset (chain reset to RESET_VAL)
//     din  : asynchronous input
//     dout : synchronized level
//     rise : one-clk pulse on synchronized 0->1
//     fall : one-clk pulse on synchronized 1->0
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] pipe_q;
    logic [STAGES-1:0] pipe_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = din;
        prev_d    = pipe_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            pipe_q <= pipe_d;
            prev_q <= prev_d;
        end
    end

    assign dout = pipe_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_nav_responder.sv
// spi_nav_responder
//   SPI mode-3 slave emulating a pmod_nav sensor: 64x8 register file with a
//   read-only identity register, burst read/write with address wrap, and a
//   host-side update port that raises a data-ready interrupt.
//   Ports:
//     clk, rst           : system clock, asynchronous active-low reset
//     sclk, cs, mosi     : SPI from master (asynchronous, synchronized here)
//     miso, miso_oe      : SPI data to master and its drive enable
//     it                 : data-ready interrupt (STATUS bit0)
//     upd_valid/addr/data: host register update port
//     busy               : a transfer is in progress
module spi_nav_responder
    import spi_nav_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       it,
    input  logic       upd_valid,
    input  logic [5:0] upd_addr,
    input  logic [7:0] upd_data,
    output logic       busy
);

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s;
    logic [SYNC_STAGES-1:0] mosi_pipe_q, mosi_pipe_d;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .din(cs),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    // mosi uses the same depth so it stays aligned with the sclk edge pulses.
    always_comb begin
        mosi_pipe_d    = mosi_pipe_q << 1;
        mosi_pipe_d[0] = mosi;
    end
    assign mosi_s = mosi_pipe_q[SYNC_STAGES-1];

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    in_sr_q, in_sr_d;
    logic [7:0]    out_sr_q, out_sr_d;
    logic [5:0]    addr_q, addr_d;
    logic          miso_q, miso_d;
    logic          busy_q, busy_d;
    logic          armed_q, armed_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic          wr_pend_q, wr_pend_d;
    logic [5:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [64];
    logic [7:0]    regs_d [64];
    logic [7:0]    byte_in;
    logic          settled;
    logic          status_clr;
    logic          status_set;

    // The synchronizers come out of reset showing an idle bus. If cs was
    // actually low across reset, that would look like a fresh cs fall once the
    // real level propagates, so cs falls are only accepted after the chains
    // have refilled from the pins and the bus has been seen idle.
    assign settled    = (settle_q == SETTLE_W'(SYNC_STAGES));
    assign status_set = upd_valid && in_out_range(upd_addr);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        in_sr_d    = in_sr_q;
        out_sr_d   = out_sr_q;
        addr_d     = addr_q;
        miso_d     = miso_q;
        busy_d     = busy_q;
        wr_pend_d  = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        status_clr = 1'b0;
        settle_d   = settled ? settle_q : settle_q + 1'b1;
        armed_d    = armed_q | (settled & cs_s & sclk_s);
        byte_in    = {in_sr_q, mosi_s};

        if (cs_rise) begin
            // Any partial byte is dropped simply by leaving the shifter.
            state_d   = IDLE;
            busy_d    = 1'b0;
            miso_d    = 1'b1;
            bit_cnt_d = 3'd0;
        end else if (cs_fall && armed_q) begin
            state_d   = CMD;
            busy_d    = 1'b1;
            miso_d    = 1'b1;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                CMD: begin
                    if (sclk_rise) begin
                        in_sr_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = byte_in[5:0];
                            if (byte_in[7]) begin
                                state_d  = READ;
                                out_sr_d = regs_q[byte_in[5:0]];
                            end else begin
                                state_d = WRITE;
                            end
                        end
                    end
                end
                READ: begin
                    if (sclk_fall) begin
                        miso_d   = out_sr_q[7];
                        out_sr_d = out_sr_q << 1;
                    end else if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            status_clr = (addr_q == OUT_LAST);
                            addr_d     = addr_q + 6'd1;
                            // Latched now; later updates to this address do
                            // not disturb the byte being shifted out.
                            out_sr_d   = regs_q[addr_q + 6'd1];
                        end
                    end
                end
                WRITE: begin
                    if (sclk_rise) begin
                        in_sr_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_pend_d = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = byte_in;
                            addr_d    = addr_q + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            in_sr_q     <= 7'd0;
            out_sr_q    <= 8'd0;
            addr_q      <= 6'd0;
            miso_q      <= 1'b1;
            busy_q      <= 1'b0;
            armed_q     <= 1'b0;
            settle_q    <= '0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= 6'd0;
            wr_data_q   <= 8'd0;
            mosi_pipe_q <= {SYNC_STAGES{1'b1}};
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            in_sr_q     <= in_sr_d;
            out_sr_q    <= out_sr_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            armed_q     <= armed_d;
            settle_q    <= settle_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            mosi_pipe_q <= mosi_pipe_d;
        end
    end

    // Register file. The SPI commit is applied after the host update so it
    // wins a same-address collision; the status set is applied after the
    // clear so it wins a same-clk collision.
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            regs_d[i] = regs_q[i];
            if (upd_valid && upd_addr == 6'(i) && 6'(i) != WHO_AM_I)
                regs_d[i] = upd_data;
            if (wr_pend_q && wr_addr_q == 6'(i) && 6'(i) != WHO_AM_I && 6'(i) != STATUS)
                regs_d[i] = wr_data_q;
        end
        if (status_clr)
            regs_d[STATUS][0] = 1'b0;
        if (status_set)
            regs_d[STATUS][0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++)
                regs_q[i] <= (i == int'(WHO_AM_I)) ? WHO_AM_I_VAL : 8'h00;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign miso    = miso_q;
    assign miso_oe = busy_q;
    assign busy    = busy_q;
    assign it      = regs_q[STATUS][0];

endmodule

// File: tb/tb_spi_nav_responder.sv
module tb_spi_nav_responder;

    localparam int H = 6;   // sclk half period in clk cycles (sclk = clk/12)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b1;
    logic       cs = 1'b1;
    logic       mosi = 1'b1;
    logic       upd_valid = 1'b0;
    logic [5:0] upd_addr = 6'd0;
    logic [7:0] upd_data = 8'd0;
    logic       miso, miso_oe, it, busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] model [64];
    logic [7:0] exp_q [$];
    logic [7:0] tx_buf [8];

    always #5 clk = ~clk;

    spi_nav_responder #(.WHO_AM_I_VAL(8'h68), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .it(it),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_data(upd_data),
        .busy(busy)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        model[6'h0F] = 8'h68;
    endtask

    task automatic host_update(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_data  = d;
        if (a != 6'h0F) model[a] = d;
        if (a >= 6'h28 && a <= 6'h2D) model[6'h27][0] = 1'b1;
        $display("upd addr=%02h data=%02h", a, d);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        check1("it_after_upd", it, model[6'h27][0]);
    endtask

    // Mode-3 master: mosi changes with sclk fall, slave samples on rise.
    // With collide set, a host update to the command address is held so its
    // last active clk is the clk where the final byte is committed: the final
    // sclk rise reaches the edge detector two clks later, the FSM captures it
    // on the third edge and the register file takes it on the fourth.
    task automatic spi_xfer(input logic [7:0] cmd, input int nbytes, input int extra_bits,
                            input bit collide, input logic [7:0] coll_data);
        logic [7:0] b;
        int nb;
        nb = 8 * (1 + nbytes) + extra_bits;
        $display("xfer cmd=%02h bytes=%0d extra_bits=%0d collide=%0d", cmd, nbytes, extra_bits, collide);
        @(negedge clk);
        cs = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            if (i < 8) b = cmd;
            else       b = tx_buf[(i - 8) / 8];
            sclk = 1'b0;
            mosi = b[7 - (i % 8)];
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            if (collide && i == nb - 1) begin
                @(negedge clk);
                upd_valid = 1'b1;
                upd_addr  = cmd[5:0];
                upd_data  = coll_data;
                repeat (3) @(negedge clk);
                upd_valid = 1'b0;
                repeat (H - 4) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        cs   = 1'b1;
        mosi = 1'b1;
        repeat (2 * H) @(negedge clk);
        check1("busy_idle", busy, 1'b0);
        check1("miso_oe_idle", miso_oe, 1'b0);
        check1("miso_idle", miso, 1'b1);
    endtask

    task automatic do_write(input logic [5:0] start, input int n);
        logic [5:0] a;
        for (int k = 0; k < n; k++) begin
            a = start + 6'(k);
            if (a != 6'h0F && a != 6'h27) model[a] = tx_buf[k];
        end
        spi_xfer({1'b0, 1'($urandom_range(0, 1)), start}, n, 0, 1'b0, 8'h00);
    endtask

    task automatic do_read(input logic [5:0] start, input int n);
        logic [5:0] a;
        bit clr;
        clr = 1'b0;
        for (int k = 0; k < n; k++) begin
            a = start + 6'(k);
            exp_q.push_back(model[a]);
            if (a == 6'h2D) clr = 1'b1;
        end
        if (clr) model[6'h27][0] = 1'b0;
        spi_xfer({1'b1, 1'($urandom_range(0, 1)), start}, n, 0, 1'b0, 8'h00);
        check1("it_after_read", it, model[6'h27][0]);
    endtask

    // Monitor: decodes each transfer from the pins as the master sees them
    // and compares every complete read byte with the scoreboard queue.
    initial begin : monitor
        logic [7:0] mcmd;
        logic [7:0] mbyte;
        int mb;
        bit cmd_ones;
        forever begin
            @(negedge cs);
            mb = 0;
            cmd_ones = 1'b1;
            mcmd = 8'h00;
            mbyte = 8'h00;
            while (cs == 1'b0) begin
                @(posedge sclk or posedge cs);
                if (cs == 1'b0) begin
                    if (mb < 8) begin
                        mcmd = {mcmd[6:0], mosi};
                        if (miso !== 1'b1) cmd_ones = 1'b0;
                        if (mb == 7) begin
                            check1("cmd_miso_high", cmd_ones, 1'b1);
                            check1("miso_oe_active", miso_oe, 1'b1);
                        end
                    end else if (mcmd[7]) begin
                        mbyte = {mbyte[6:0], miso};
                        if (mb % 8 == 7) begin
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL read_data: got %02h expected nothing queued", mbyte);
                            end else begin
                                check8("read_data", mbyte, exp_q.pop_front());
                            end
                        end
                    end
                    mb++;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [5:0] ra;
        int n;
        model_reset();
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        check1("rst_busy", busy, 1'b0);
        check1("rst_miso_oe", miso_oe, 1'b0);
        check1("rst_miso", miso, 1'b1);
        check1("rst_it", it, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // identity register
        do_read(6'h0F, 1);

        // write pair then burst read back
        tx_buf[0] = 8'hA5; tx_buf[1] = 8'h5A;
        do_write(6'h10, 2);
        do_read(6'h10, 2);

        // wrap 63 -> 0
        tx_buf[0] = 8'h11;
        do_write(6'h3F, 1);
        tx_buf[0] = 8'h22; tx_buf[1] = 8'h33;
        do_write(6'h00, 2);
        do_read(6'h3F, 3);

        // data-ready set by host, cleared by reading through 0x2D
        host_update(6'h2A, 8'h9C);
        do_read(6'h28, 6);

        // partial write byte is discarded
        tx_buf[0] = 8'h77;
        do_write(6'h20, 1);
        tx_buf[0] = 8'hEE;
        spi_xfer({2'b00, 6'h20}, 0, 4, 1'b0, 8'h00);
        do_read(6'h20, 1);

        // host update and SPI commit collide on 0x30: SPI wins
        tx_buf[0] = 8'hC3;
        model[6'h30] = 8'hC3;
        spi_xfer({2'b00, 6'h30}, 1, 0, 1'b1, 8'h3C);
        do_read(6'h30, 1);

        // SPI writes to identity and status are ignored
        tx_buf[0] = 8'h55;
        do_write(6'h0F, 1);
        tx_buf[0] = 8'hFF;
        do_write(6'h27, 1);
        do_read(6'h0E, 2);
        do_read(6'h27, 1);

        // randomized mix
        for (int t = 0; t < 30; t++) begin
            ra = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 2))
                0: host_update(ra, 8'($urandom));
                1: begin
                    n = $urandom_range(1, 3);
                    for (int k = 0; k < n; k++) tx_buf[k] = 8'($urandom);
                    do_write(ra, n);
                end
                default: do_read(ra, $urandom_range(1, 4));
            endcase
        end

        // reset in the middle of a transfer, cs held low across release
        @(negedge clk);
        cs = 1'b0;
        repeat (3 * H) @(negedge clk);
        check1("busy_before_abort", busy, 1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        check1("abort_busy", busy, 1'b0);
        check1("abort_miso_oe", miso_oe, 1'b0);
        check1("abort_miso", miso, 1'b1);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check1("no_resume_busy", busy, 1'b0);
        check1("no_resume_it", it, 1'b0);
        cs = 1'b1;
        repeat (2 * H) @(negedge clk);
        do_read(6'h10, 2);
        do_read(6'h0F, 1);

        repeat (10) @(negedge clk);
        check8("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
